// File: rtl/phase_seq_pkg.sv
// Shared phase codes, FSM states and the frame successor lookup for the
// phase generator / decoder pair.
package phase_seq_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        CH1   = 3'd1,
        AZERO = 3'd2,
        CH2   = 3'd3,
        REST  = 3'd4,
        MULTI = 3'd7
    } phase_e;

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_e;

    localparam int PHASE_LEN_MAX = 63;

    // Frame order CH1 -> AZERO -> CH2 -> REST -> CH1; NONE/MULTI have no successor.
    function automatic phase_e nextPhase(input phase_e p);
        case (p)
            CH1:     nextPhase = AZERO;
            AZERO:   nextPhase = CH2;
            CH2:     nextPhase = REST;
            REST:    nextPhase = CH1;
            default: nextPhase = NONE;
        endcase
    endfunction

endpackage

// File: rtl/phase_seq_checker_in.sv
// Input stage S1 for the phase decoder: registers the phase lines and counter,
// decodes the phase and flags inversion, overlap and counter-skip violations.
module phase_seq_checker_in
    import phase_seq_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ch1_i,
    input  logic       ch1Inv_i,
    input  logic       aZero_i,
    input  logic       rest_i,
    input  logic       ch2_i,
    input  logic       ch2Inv_i,
    input  logic [5:0] count_i,
    output phase_e     phaseDec_o,
    output logic       invBad_o,
    output logic       overlap_o,
    output logic       cntBad_o
);

    logic       s1Ch1_q, s1Ch1Inv_q, s1AZero_q, s1Rest_q, s1Ch2_q, s1Ch2Inv_q;
    logic [5:0] s1Count_q;
    logic       s1Valid_q;
    logic [5:0] prevCount_q;
    logic       prevValid_q;

    // The valid flags keep the zeroed post-reset S1 contents from raising errors.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1Ch1_q     <= 1'b0;
            s1Ch1Inv_q  <= 1'b0;
            s1AZero_q   <= 1'b0;
            s1Rest_q    <= 1'b0;
            s1Ch2_q     <= 1'b0;
            s1Ch2Inv_q  <= 1'b0;
            s1Count_q   <= 6'd0;
            s1Valid_q   <= 1'b0;
            prevCount_q <= 6'd0;
            prevValid_q <= 1'b0;
        end else begin
            s1Ch1_q     <= ch1_i;
            s1Ch1Inv_q  <= ch1Inv_i;
            s1AZero_q   <= aZero_i;
            s1Rest_q    <= rest_i;
            s1Ch2_q     <= ch2_i;
            s1Ch2Inv_q  <= ch2Inv_i;
            s1Count_q   <= count_i;
            s1Valid_q   <= 1'b1;
            prevCount_q <= s1Count_q;
            prevValid_q <= s1Valid_q;
        end
    end

    always_comb begin
        phaseDec_o = NONE;
        case ({s1Ch1_q, s1AZero_q, s1Ch2_q, s1Rest_q})
            4'b0000: phaseDec_o = NONE;
            4'b1000: phaseDec_o = CH1;
            4'b0100: phaseDec_o = AZERO;
            4'b0010: phaseDec_o = CH2;
            4'b0001: phaseDec_o = REST;
            default: phaseDec_o = MULTI;
        endcase
    end

    assign invBad_o  = s1Valid_q && ((s1Ch1Inv_q == s1Ch1_q) || (s1Ch2Inv_q == s1Ch2_q));
    assign overlap_o = (phaseDec_o == MULTI);
    assign cntBad_o  = s1Valid_q && prevValid_q && (s1Count_q != prevCount_q + 6'd1);

endmodule

// File: rtl/phase_seq_decoder.sv
// Receive-side phase sequence decoder: locks onto CH1->AZERO->CH2->REST frames and
// emits sample/frame strobes. Define PHASE_SEQ_STATS_EN to add per-phase length outputs.
module phase_seq_decoder
    import phase_seq_pkg::*;
#(
    parameter int MIN_PHASE_LEN = 2,
    parameter int FRAME_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ch1,
    input  logic                   ch1_inv,
    input  logic                   a_zero,
    input  logic                   rest,
    input  logic                   ch2,
    input  logic                   ch2_inv,
    input  logic [5:0]             count,
    input  logic                   err_clr,
    output logic [2:0]             phase,
    output logic                   locked,
    output logic                   sample1,
    output logic                   sample2,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   inv_err,
    output logic                   overlap_err,
    output logic                   seq_err,
`ifdef PHASE_SEQ_STATS_EN
    output logic [5:0]             len_ch1,
    output logic [5:0]             len_azero,
    output logic [5:0]             len_ch2,
    output logic [5:0]             len_rest,
    output logic                   len_mismatch,
`endif
    output logic                   cnt_err
);

    localparam logic [5:0] MinLen = 6'(MIN_PHASE_LEN);
    localparam logic [5:0] LenMax = 6'(PHASE_LEN_MAX);

    phase_e cur;
    logic   invBad, overlapBad, cntBad;

    phase_seq_checker_in uChecker (
        .clk_i      (clk),
        .rst_i      (rst),
        .ch1_i      (ch1),
        .ch1Inv_i   (ch1_inv),
        .aZero_i    (a_zero),
        .rest_i     (rest),
        .ch2_i      (ch2),
        .ch2Inv_i   (ch2_inv),
        .count_i    (count),
        .phaseDec_o (cur),
        .invBad_o   (invBad),
        .overlap_o  (overlapBad),
        .cntBad_o   (cntBad)
    );

    state_e                 state_q;
    phase_e                 phase_q;
    logic [5:0]             len_q;
    logic                   locked_q, sample1_q, sample2_q, frameDone_q;
    logic [FRAME_CNT_W-1:0] frameCnt_q;
    logic                   invErr_q, overlapErr_q, seqErr_q, cntErr_q;
`ifdef PHASE_SEQ_STATS_EN
    logic [5:0]             lenCh1_q, lenAZero_q, lenCh2_q, lenRest_q;
    logic                   lenMismatch_q;
`endif

    // phase_q holds the previous decode, so a change is seen as cur != phase_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SYNC;
            phase_q      <= NONE;
            len_q        <= 6'd0;
            locked_q     <= 1'b0;
            sample1_q    <= 1'b0;
            sample2_q    <= 1'b0;
            frameDone_q  <= 1'b0;
            frameCnt_q   <= '0;
            invErr_q     <= 1'b0;
            overlapErr_q <= 1'b0;
            seqErr_q     <= 1'b0;
            cntErr_q     <= 1'b0;
`ifdef PHASE_SEQ_STATS_EN
            lenCh1_q      <= 6'd0;
            lenAZero_q    <= 6'd0;
            lenCh2_q      <= 6'd0;
            lenRest_q     <= 6'd0;
            lenMismatch_q <= 1'b0;
`endif
        end else begin
            phase_q      <= cur;
            sample1_q    <= 1'b0;
            sample2_q    <= 1'b0;
            frameDone_q  <= 1'b0;
            invErr_q     <= invBad | (invErr_q & ~err_clr);
            overlapErr_q <= overlapBad | (overlapErr_q & ~err_clr);
            cntErr_q     <= cntBad | (cntErr_q & ~err_clr);
            seqErr_q     <= seqErr_q & ~err_clr;
`ifdef PHASE_SEQ_STATS_EN
            lenMismatch_q <= lenMismatch_q & ~err_clr;
`endif
            case (state_q)
                SYNC: begin
                    locked_q <= 1'b0;
                    len_q    <= 6'd0;
                    if (cur == CH1 && phase_q != CH1) begin
                        state_q  <= TRACK;
                        locked_q <= 1'b1;
                        len_q    <= 6'd1;
                    end
                end
                TRACK: begin
                    if (cur == phase_q) begin
                        len_q <= (len_q == LenMax) ? len_q : len_q + 6'd1;
                    end else if (cur == nextPhase(phase_q) && len_q >= MinLen) begin
                        len_q     <= 6'd1;
                        sample1_q <= (phase_q == CH1);
                        sample2_q <= (phase_q == CH2);
                        if (phase_q == REST) begin
                            frameDone_q <= 1'b1;
                            frameCnt_q  <= frameCnt_q + FRAME_CNT_W'(1);
                        end
`ifdef PHASE_SEQ_STATS_EN
                        case (phase_q)
                            CH1:   lenCh1_q   <= len_q;
                            AZERO: lenAZero_q <= len_q;
                            CH2: begin
                                lenCh2_q <= len_q;
                                if (len_q != lenCh1_q) lenMismatch_q <= 1'b1;
                            end
                            REST:  lenRest_q  <= len_q;
                            default: ;
                        endcase
`endif
                    end else begin
                        state_q  <= SYNC;
                        locked_q <= 1'b0;
                        seqErr_q <= 1'b1;
                        len_q    <= 6'd0;
                    end
                end
                default: state_q <= SYNC;
            endcase
        end
    end

    assign phase       = phase_q;
    assign locked      = locked_q;
    assign sample1     = sample1_q;
    assign sample2     = sample2_q;
    assign frame_done  = frameDone_q;
    assign frame_cnt   = frameCnt_q;
    assign inv_err     = invErr_q;
    assign overlap_err = overlapErr_q;
    assign seq_err     = seqErr_q;
    assign cnt_err     = cntErr_q;
`ifdef PHASE_SEQ_STATS_EN
    assign len_ch1      = lenCh1_q;
    assign len_azero    = lenAZero_q;
    assign len_ch2      = lenCh2_q;
    assign len_rest     = lenRest_q;
    assign len_mismatch = lenMismatch_q;
`endif

endmodule

// File: doc/phase_seq_decoder.md
Name: phase_seq_decoder

Overview:
- Receive-side companion to the channel phase generator (`clks`) in the auto-transistor datapath.
- Inputs: the six phase lines (ch1, ch1_inv, a_zero, rest, ch2, ch2_inv) plus the 6-bit phase counter.
- Decodes the current phase, locks onto the frame sequence CH1 -> AZERO -> CH2 -> REST, and emits sample strobes and frame pulses to the measurement logic.
- Flags protocol violations: inversion mismatch, overlap, illegal order, short phase, counter skip.

Parameters:
- MIN_PHASE_LEN, 2, minimum legal cycles per phase; 1..63.
- FRAME_CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- ch1  in  1  channel 1 drive phase
- ch1_inv  in  1  complement of ch1
- a_zero  in  1  auto-zero phase
- rest  in  1  rest phase
- ch2  in  1  channel 2 drive phase
- ch2_inv  in  1  complement of ch2
- count  in  6  generator phase counter
- phase  out  3  decoded phase: 0 NONE, 1 CH1, 2 AZERO, 3 CH2, 4 REST, 7 MULTI
- locked  out  1  sequence lock achieved
- sample1  out  1  one-cycle pulse on the last CH1 cycle
- sample2  out  1  one-cycle pulse on the last CH2 cycle
- frame_done  out  1  one-cycle pulse on REST -> CH1
- frame_cnt  out  FRAME_CNT_W  completed frames, wraps
- inv_err  out  1  sticky error flag
- overlap_err  out  1  sticky error flag
- seq_err  out  1  sticky error flag
- cnt_err  out  1  sticky error flag
- err_clr  in  1  clears all sticky errors; rst has priority

Behaviour:
- Input stage:
  - All 7 inputs are registered once (stage S1).
  - Decode and check run on S1; outputs are registered.
  - Latency: a value sampled at edge N is visible on outputs after edge N+1.
- Phase decode, from S1:
  - Exactly one of ch1 / a_zero / ch2 / rest high -> that phase.
  - None high -> NONE.
  - More than one high -> MULTI.
- Inversion check: ch1_inv != ~ch1 or ch2_inv != ~ch2 in any cycle after reset -> inv_err.
- Overlap: phase == MULTI -> overlap_err.
- Counter check:
  - After the first post-reset sample, count must equal prev + 1 mod 64; otherwise cnt_err.
  - 63 -> 0 is legal.
- FSM states: SYNC, TRACK.
  - SYNC (reset state): locked = 0. Ignores order and length checks. Goes to TRACK on the first cycle where phase changes from non-CH1 to CH1.
  - TRACK: locked = 1. Tracks len = cycles in the current phase, saturating at 63.
  - On a phase change, the new phase must be the successor (CH1 -> AZERO -> CH2 -> REST -> CH1), and the old phase len must be >= MIN_PHASE_LEN.
  - Any violation, including entering NONE or MULTI: set seq_err, return to SYNC, locked drops on the same output update.
- Strobes:
  - sample1 fires in the cycle the CH1 -> AZERO change is decoded (TRACK only); sample2 likewise for CH2 -> REST.
  - frame_done fires on a legal REST -> CH1; frame_cnt increments in the same cycle.
  - No strobes in SYNC, or on the violating transition.
- Sticky errors: set and clear in the same cycle -> set wins.
- Reset values:
  - All outputs 0 (phase = NONE); FSM in SYNC.
  - len = 0; the prev-count valid flag is cleared.
  - Reset mid-frame discards the frame; relock requires a fresh CH1 entry.

Optional Feature:
- Macro PHASE_SEQ_STATS_EN.
- When defined:
  - Adds outputs len_ch1, len_azero, len_ch2, len_rest (6 bits each).
  - Each is latched with the measured length of that phase on its legal exit in TRACK; reset 0.
  - Adds len_mismatch (sticky, cleared by err_clr): asserted when a frame's CH1 length differs from its CH2 length.
- When undefined: those ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package phase_seq_pkg holds:
  - phase code constants: NONE, CH1, AZERO, CH2, REST, MULTI.
  - FSM state constants: SYNC, TRACK.
  - The successor function: next-phase lookup.
- The generator and its testbench reuse the same phase codes.
- One sub-module: phase_seq_checker_in, the input register plus decode, inversion, overlap and count checks; the top holds the FSM, strobes and counters.

Test Plan:
- Legal generator stimulus, 8 cycles per phase, count incrementing from 0:
  - locked rises 1 cycle after the first CH1 decode.
  - sample1 and sample2 pulse once per frame; frame_cnt = 3 after 3 full frames; no errors.
- Force ch1_inv = ch1 for 1 cycle mid-CH1:
  - inv_err = 1 two edges later and stays 1.
  - err_clr pulse -> 0 next edge.
- Drive ch1 and ch2 high together for 1 cycle in TRACK:
  - overlap_err = 1, seq_err = 1, locked = 0.
  - Relock on the next CH1 entry; no sample2 for the broken frame.
- Skip AZERO (CH1 -> CH2): seq_err = 1, state SYNC, no sample1.
- With MIN_PHASE_LEN = 2, a 1-cycle AZERO: seq_err = 1.
- Count sequence 5, 6, 8: cnt_err = 1. Wrap 63 -> 0: no error.
- Assert rst mid-CH2 for 1 cycle:
  - All outputs 0, phase = NONE.
  - The next REST -> CH1 produces no frame_done; locked reasserts on that CH1 entry.
